root_scan: RTL
==============

ROOT_SCAN -- requirements
Module: root_scan

Interface
REQ-001 Parameter gf, default 13: field element width in bits.
REQ-002 Parameter mem_width, default 8: evaluation memory width; each read word carries 2*mem_width elements.
REQ-003 Parameter depth, default 256: number of evaluation words to scan; addr_w = CLOG2(depth).
REQ-004 Parameter sys_t, default 64: expected root count, used only under REQ-026.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse; begins a scan.
REQ-008 rd_en  output  1  read enable to the additive-FFT evaluation memory.
REQ-009 rd_addr  output  addr_w  evaluation word address.
REQ-010 data_in  input  2*mem_width*gf  evaluation word; valid exactly one cycle after rd_en.
REQ-011 err_valid  output  1  err_word valid this cycle.
REQ-012 err_ready  input  1  downstream accepts err_word when err_valid and err_ready are both high.
REQ-013 err_word  output  2*mem_width  error bits; bit i = 1 iff element i is zero.
REQ-014 err_idx  output  addr_w  word index of err_word.
REQ-015 root_cnt  output  CLOG2(depth*2*mem_width+1)  running count of zero elements.
REQ-016 busy  output  1  high from the cycle after start until done.
REQ-017 done  output  1  one-cycle pulse at scan completion.

Function
REQ-018 States IDLE, SCAN, DRAIN, FIN; IDLE->SCAN on start; SCAN->DRAIN after issuing address depth-1; DRAIN->FIN when the last word is accepted; FIN->IDLE after one cycle, with done=1 in FIN.
REQ-019 On entering SCAN: root_cnt cleared to 0 and rd_addr = 0; each issued read increments rd_addr by 1, no wrap-around beyond depth-1.
REQ-020 Element i occupies data_in[i*gf +: gf]; err_word[i] = (element == 0), combinationally derived from the registered word.
REQ-021 The block holds a 2-entry output buffer (output register plus skid register); rd_en is asserted only when the buffer holds at most one entry and no read is in flight that would overfill it, so no data is lost when err_ready is low.
REQ-022 Throughput with err_ready held high: one word per cycle; the first err_valid appears 2 cycles after start, and done appears depth+2 cycles after the cycle in which start is sampled.
REQ-023 root_cnt adds popcount(err_word) on each accepted transfer; it holds its final value after done until the next start.
REQ-024 While busy, start is ignored; start sampled in the same cycle as done (FIN) is also ignored.
REQ-025 Output words are emitted in ascending err_idx order, 0..depth-1, exactly once each.

Configuration
REQ-026 Macro ROOT_SCAN_WEIGHT_CHECK_EN: when defined, an extra output port decode_fail (output, 1 bit) is added; it is set in FIN iff root_cnt != sys_t, is held until the next start, and is cleared by reset; when undefined, the port and its logic are absent and all other behaviour is identical.

Reset
REQ-027 rst high forces the block to IDLE asynchronously, clears the buffer, and drives rd_en=0, rd_addr=0, err_valid=0, err_word=0, err_idx=0, root_cnt=0, busy=0, and done=0.
REQ-028 A reset asserted mid-scan aborts the scan without asserting done; any in-flight read data returned after reset is discarded.

Verification
REQ-029 gf=13, mem_width=8, depth=4, all elements nonzero, err_ready=1 -> 4 words with err_word=0, root_cnt=0, done at start+6.
REQ-030 Word 2 with elements 0 and 15 zero, err_ready=1 -> err_idx=2, err_word=16'h8001, final root_cnt=2.
REQ-031 err_ready toggled 1,0,0,1 repeatedly -> all 4 words are delivered in order, none dropped or duplicated, and rd_addr never exceeds 3.
REQ-032 start pulsed again while busy, and again in the done cycle -> both are ignored; exactly one done pulse results.
REQ-033 rst asserted during SCAN at rd_addr=2 -> all outputs are 0 in the same cycle; a subsequent start scans from address 0.
REQ-034 With ROOT_SCAN_WEIGHT_CHECK_EN defined and sys_t=2: the REQ-030 stimulus gives decode_fail=0; all-nonzero data gives decode_fail=1.

Source files
------------

// File: rtl/root_scan.sv
// root_scan: streams evaluation words, flags zero elements per word and counts roots; optional ROOT_SCAN_WEIGHT_CHECK_EN adds decode_fail
module root_scan #(
  parameter int gf = 13,
  parameter int mem_width = 8,
  parameter int depth = 256,
  parameter int sys_t = 64,
  localparam int aw = $clog2(depth),
  localparam int ew = 2 * mem_width,
  localparam int cw = $clog2(((depth * ew > sys_t) ? depth * ew : sys_t) + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             rd_en,
  output logic [aw-1:0]    rd_addr,
  input  logic [ew*gf-1:0] data_in,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [ew-1:0]    err_word,
  output logic [aw-1:0]    err_idx,
  output logic [cw-1:0]    root_cnt,
  output logic             busy,
  output logic             done
`ifdef ROOT_SCAN_WEIGHT_CHECK_EN
  , output logic           decode_fail
`endif
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;
  localparam logic [aw-1:0] last = aw'(depth - 1);
  state_t state, state_n;
  logic [1:0] cnt;
  logic pend, go, push, pop;
  logic [ew-1:0] zf, skid_w;
  logic [aw-1:0] cap_idx, skid_idx;

  function automatic logic [cw-1:0] pc(input logic [ew-1:0] w);
    logic [cw-1:0] s;
    s = '0;
    for (int i = 0; i < ew; i++) s = s + cw'(w[i]);
    return s;
  endfunction

  assign go = state == IDLE && start;
  assign push = pend;
  assign pop = err_valid && err_ready;
  assign err_valid = cnt != 2'd0;
  assign busy = state == SCAN || state == DRAIN;
  assign done = state == FIN;
  // reads are issued only if the buffer can still hold the result even with no pop next cycle
  assign rd_en = state == SCAN && (cnt + 2'(pend) - 2'(pop) <= 2'd1);

  // zero flag per element of the word returned by memory
  always_comb begin
    zf = '0;
    for (int i = 0; i < ew; i++) zf[i] = data_in[i*gf +: gf] == '0;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SCAN;
      SCAN:    if (rd_en && rd_addr == last) state_n = DRAIN;
      DRAIN:   if (pop && err_idx == last) state_n = FIN;
      default: state_n = IDLE;
    endcase
  end

  // state, read address and read-in-flight flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pend <= 1'b0;
      rd_addr <= '0;
    end else begin
      state <= state_n;
      pend <= rd_en;
      if (go) rd_addr <= '0;
      else if (rd_en && rd_addr != last) rd_addr <= rd_addr + 1'b1;
    end

  // two-entry output buffer (output register plus skid) and root counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      err_word <= '0;
      err_idx <= '0;
      skid_w <= '0;
      skid_idx <= '0;
      cap_idx <= '0;
      root_cnt <= '0;
    end else if (go) begin
      cap_idx <= '0;
      root_cnt <= '0;
    end else begin
      cnt <= cnt + 2'(push) - 2'(pop);
      if (push) cap_idx <= cap_idx + 1'b1;
      if (pop) root_cnt <= root_cnt + pc(err_word);
      if ((pop || cnt == 2'd0) && (push || cnt == 2'd2)) begin
        err_word <= cnt == 2'd2 ? skid_w : zf;
        err_idx <= cnt == 2'd2 ? skid_idx : cap_idx;
      end
      if (push && (cnt == 2'd2 || (cnt == 2'd1 && !pop))) begin
        skid_w <= zf;
        skid_idx <= cap_idx;
      end
    end

`ifdef ROOT_SCAN_WEIGHT_CHECK_EN
  logic fail_q;
  // latch the weight verdict at completion, held until the next scan
  always_ff @(posedge clk or posedge rst)
    if (rst) fail_q <= 1'b0;
    else if (go) fail_q <= 1'b0;
    else if (state == FIN) fail_q <= root_cnt != cw'(sys_t);
  assign decode_fail = state == FIN ? root_cnt != cw'(sys_t) : fail_q;
`endif
endmodule
